// File: rtl/mod_pkg.sv
// Shared types and helpers for the modular-reduction block.
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        FIXUP,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/reg_256.sv
// Parametrised load-enable register with synchronous active-low clear.
module reg_256 #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mod_reduce.sv
// Sequential signed-operand modular reduction: k mod `mod` by restoring
// shift-subtract over |k|, with a sign fix-up and fixed latency.
module mod_reduce
    import mod_pkg::*;
#(
    parameter int KW = 16,
    parameter int MW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [KW-1:0] k,
    input  logic [MW-1:0] mod,
    output logic [MW-1:0] out,
    output logic          Done,
    output logic          Busy,
    output logic          Err
);

    localparam int CW = clog2(KW + 1);

    state_t        state, next;
    logic [KW-1:0] mag;
    logic          sign;
    logic [MW-1:0] mod_q;
    logic [MW:0]   r;
    logic [CW-1:0] cnt;
    logic          last;
    logic [MW:0]   r_shift;
    logic [MW:0]   r_next;
    logic [MW-1:0] res;
    logic          out_en;
    logic [MW-1:0] out_d;

    assign last    = (cnt == CW'(KW - 1));
    assign r_shift = {r[MW-1:0], mag[KW-1]};
    assign r_next  = (r_shift >= {1'b0, mod_q}) ? (r_shift - {1'b0, mod_q}) : r_shift;
    assign res     = (sign && (r != '0)) ? (mod_q - r[MW-1:0]) : r[MW-1:0];
    assign Busy    = (state != IDLE);

    // A zero modulus skips the datapath and publishes 0 straight away.
    assign out_en = (state == FIXUP) || ((state == IDLE) && Start && (mod == '0));
    assign out_d  = (state == FIXUP) ? res : '0;

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (Start) next = (mod == '0) ? DONE : REDUCE;
            REDUCE:  if (last) next = FIXUP;
            FIXUP:   next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Done/Err are registered off the DONE state, so the pulse lands one
    // cycle after DONE, when the FSM is already back in IDLE.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r     <= '0;
            cnt   <= '0;
            mag   <= '0;
            sign  <= 1'b0;
            mod_q <= '0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            Done <= (state == DONE);
            Err  <= (state == DONE) && (mod_q == '0);
            case (state)
                IDLE: begin
                    if (Start) begin
                        mod_q <= mod;
                        sign  <= k[KW-1];
                        mag   <= k[KW-1] ? (~k + 1'b1) : k;
                        r     <= '0;
                        cnt   <= '0;
                    end
                end
                REDUCE: begin
                    r   <= r_next;
                    mag <= mag << 1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    reg_256 #(.W(MW)) u_out (
        .clk   (Clk),
        .reset (Reset),
        .en    (out_en),
        .d     (out_d),
        .q     (out)
    );

endmodule

// File: tb/tb_mod_reduce.sv
// Directed and randomized checks of mod_reduce against an arithmetic model.
module tb_mod_reduce;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] k     = '0;
    logic [7:0]  mod   = '0;
    logic [7:0]  out;
    logic        Done;
    logic        Busy;
    logic        Err;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    mod_reduce #(.KW(16), .MW(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .k     (k),
        .mod   (mod),
        .out   (out),
        .Done  (Done),
        .Busy  (Busy),
        .Err   (Err)
    );

    function automatic int model(input int kk, input int mm);
        int m;
        if (mm == 0) return 0;
        m = kk % mm;
        if (m < 0) m = m + mm;
        return m;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s %s: observed %0d expected %0d", tag, what, obs, exp);
        end
    endtask

    // glitch >= 0 pulses Start (with k=1, mod=3) in the cycle after edge t+glitch.
    task automatic run_op(input string tag, input logic [15:0] kk, input logic [7:0] mm, input int glitch);
        int          lat;
        int          exp_lat;
        int          exp_out;
        logic        seen;
        logic        stable;
        logic [7:0]  prev;
        exp_lat = (mm == 0) ? 1 : 18;
        exp_out = model($signed(kk), int'(mm));
        @(negedge Clk);
        Start = 1'b1; k = kk; mod = mm;
        @(posedge Clk); #1;
        Start = 1'b0; k = 16'($urandom); mod = 8'($urandom);
        prev = out; stable = 1'b1; seen = 1'b0; lat = 0;
        while (!seen && lat < 40) begin
            if (lat == glitch) begin
                Start = 1'b1; k = 16'd1; mod = 8'd3;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
            lat++;
            if (Done) seen = 1'b1;
            else if (lat < exp_lat - 1 && out !== prev) stable = 1'b0;
        end
        Start = 1'b0;
        chk(tag, "done_seen", 32'(seen), 32'd1);
        chk(tag, "latency", 32'(lat), 32'(exp_lat));
        chk(tag, "out", 32'(out), 32'(exp_out));
        chk(tag, "err", 32'(Err), 32'(mm == 0));
        chk(tag, "busy_at_done", 32'(Busy), 32'd0);
        chk(tag, "out_stable", 32'(stable), 32'd1);
        @(posedge Clk); #1;
        chk(tag, "done_single", 32'(Done), 32'd0);
        chk(tag, "err_low_after", 32'(Err), 32'd0);
        chk(tag, "idle_after", 32'(Busy), 32'd0);
    endtask

    initial begin
        logic seen;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset", "out", 32'(out), 32'd0);
        chk("reset", "done", 32'(Done), 32'd0);
        chk("reset", "busy", 32'(Busy), 32'd0);
        chk("reset", "err", 32'(Err), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("k100_m7", 16'd100, 8'd7, -1);
        run_op("km5_m7", 16'hFFFB, 8'd7, -1);
        run_op("km14_m7", 16'hFFF2, 8'd7, -1);
        run_op("kmin_m255", 16'h8000, 8'd255, -1);
        run_op("kmax_m255", 16'h7FFF, 8'd255, -1);
        run_op("k50_m0", 16'd50, 8'd0, -1);
        run_op("km77_m1", 16'hFFB3, 8'd1, -1);
        run_op("start_busy", 16'd100, 8'd7, 5);
        run_op("start_done", 16'd200, 8'd9, 17);
        run_op("k100_m7_b", 16'd100, 8'd7, -1);

        // Abort an in-flight reduction with reset on its eighth edge.
        @(negedge Clk);
        Start = 1'b1; k = 16'd100; mod = 8'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        chk("abort", "busy", 32'(Busy), 32'd0);
        chk("abort", "out", 32'(out), 32'd0);
        chk("abort", "done", 32'(Done), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk); #1;
            if (Done) seen = 1'b1;
        end
        chk("abort", "no_done", 32'(seen), 32'd0);
        run_op("after_abort", 16'd9, 8'd4, -1);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] rk;
            logic [7:0]  rm;
            rk = 16'($urandom);
            rm = (i == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op($sformatf("rand%0d", i), rk, rm, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
